// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions used by the log-unit arbiter:
// operand/result bundle widths, the QNAN abort response and the sequencer states.
package lampFPU_pkg;

   localparam int LAMP_LOG_OP_DW  = 22;
   localparam int LAMP_LOG_RES_DW = 24;

   // {s, e[7:0], f[11:0], isOverflow, isUnderflow, isToRound} for a quiet NaN
   localparam logic [LAMP_LOG_RES_DW-1:0] LAMP_LOG_QNAN_RES =
      {1'b0, 8'hFF, 12'b0100_0000_0000, 3'b000};

   typedef enum logic [1:0] {
      LOG_IDLE,
      LOG_ISSUE,
      LOG_WAIT,
      LOG_RESP
   } lampLogArbState_t;

endpackage

// File: rtl/lampfpu_rr_picker.sv
// Combinational round-robin search: first requester at or above ptr_i (with wrap-around)
// wins, reported both one-hot and as an index.
module lampfpu_rr_picker #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic             found;
   logic [IDX_W-1:0] slot;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      slot  = '0;
      for (int i = 0; i < NREQ; i++) begin
         slot = IDX_W'((int'(ptr_i) + i) % NREQ);
         if (!found && req_i[slot]) begin
            found       = 1'b1;
            gnt_o[slot] = 1'b1;
            idx_o       = slot;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/lampfpu_log_arbiter.sv
// Shares one bfloat16 log datapath among NREQ requesters: round-robin accept, single-cycle
// doLog issue, watchdog-guarded wait, and a valid/ready response back to the granted requester.
module lampfpu_log_arbiter
   import lampFPU_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15,
   parameter int CNT_DW  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NREQ-1:0]                 req_valid_i,
   input  logic [NREQ*LAMP_LOG_OP_DW-1:0]  req_op_i,
   output logic [NREQ-1:0]                 req_ready_o,
   output logic                            doLog_o,
   output logic [LAMP_LOG_OP_DW-1:0]       unit_op_o,
   input  logic                            unit_valid_i,
   input  logic [LAMP_LOG_RES_DW-1:0]      unit_res_i,
   output logic [NREQ-1:0]                 rsp_valid_o,
   input  logic [NREQ-1:0]                 rsp_ready_i,
   output logic [LAMP_LOG_RES_DW-1:0]      rsp_data_o,
   output logic                            rsp_timeout_o,
   output logic                            busy_o,
   output logic [CNT_DW-1:0]               done_cnt_o
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   lampLogArbState_t             state_q, state_d;
   logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]             gnt_q, gnt_d;
   logic [LAMP_LOG_OP_DW-1:0]    op_q, op_d;
   logic [LAMP_LOG_RES_DW-1:0]   res_q, res_d;
   logic [WD_W-1:0]              wd_q, wd_d;
   logic                         tmo_q, tmo_d;
   logic [CNT_DW-1:0]            cnt_q, cnt_d;

   logic [NREQ-1:0]              pick_gnt;
   logic [IDX_W-1:0]             pick_idx;
   logic                         pick_any;

   lampfpu_rr_picker #(
      .NREQ (NREQ)
   ) u_picker (
      .req_i (req_valid_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= LOG_IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         op_q     <= '0;
         res_q    <= '0;
         wd_q     <= '0;
         tmo_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         op_q     <= op_d;
         res_q    <= res_d;
         wd_q     <= wd_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      gnt_d         = gnt_q;
      op_d          = op_q;
      res_d         = res_q;
      wd_d          = wd_q;
      tmo_d         = tmo_q;
      cnt_d         = cnt_q;
      req_ready_o   = '0;
      doLog_o       = 1'b0;
      rsp_valid_o   = '0;
      rsp_data_o    = '0;
      rsp_timeout_o = 1'b0;
      unique case (state_q)
         LOG_IDLE: begin
            if (pick_any) begin
               req_ready_o = pick_gnt;
               op_d        = req_op_i[int'(pick_idx)*LAMP_LOG_OP_DW +: LAMP_LOG_OP_DW];
               gnt_d       = pick_idx;
               state_d     = LOG_ISSUE;
            end
         end
         LOG_ISSUE: begin
            doLog_o = 1'b1;
            wd_d    = '0;
            state_d = LOG_WAIT;
         end
         LOG_WAIT: begin
            wd_d = wd_q + 1'b1;
            // A result landing on the abort cycle still wins over the watchdog
            if (unit_valid_i) begin
               res_d   = unit_res_i;
               tmo_d   = 1'b0;
               state_d = LOG_RESP;
            end else if (wd_q == WD_W'(TIMEOUT)) begin
               res_d   = LAMP_LOG_QNAN_RES;
               tmo_d   = 1'b1;
               state_d = LOG_RESP;
            end
         end
         LOG_RESP: begin
            rsp_valid_o   = NREQ'(1) << gnt_q;
            rsp_data_o    = res_q;
            rsp_timeout_o = tmo_q;
            if (rsp_ready_i[gnt_q]) begin
               rr_ptr_d = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
               cnt_d    = cnt_q + 1'b1;
               state_d  = LOG_IDLE;
            end
         end
         default: state_d = LOG_IDLE;
      endcase
   end

   assign unit_op_o  = op_q;
   assign busy_o     = (state_q != LOG_IDLE);
   assign done_cnt_o = cnt_q;

endmodule

// File: tb/tb_lampfpu_log_arbiter.sv
// Scoreboard bench for lampfpu_log_arbiter: random requesters, a behavioural log unit
// with per-operation latency plans, and a decoupled response monitor.
module tb_lampfpu_log_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 15;
   localparam int CNT_DW  = 3;
   localparam logic [23:0] QNAN = 24'h7FA000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid_i;
   logic [NREQ*22-1:0]   req_op_i;
   logic [NREQ-1:0]      req_ready_o;
   logic                 doLog_o;
   logic [21:0]          unit_op_o;
   logic                 unit_valid_i;
   logic [23:0]          unit_res_i;
   logic [NREQ-1:0]      rsp_valid_o;
   logic [NREQ-1:0]      rsp_ready_i;
   logic [23:0]          rsp_data_o;
   logic                 rsp_timeout_o;
   logic                 busy_o;
   logic [CNT_DW-1:0]    done_cnt_o;

   lampfpu_log_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT),
      .CNT_DW  (CNT_DW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_op_i      (req_op_i),
      .req_ready_o   (req_ready_o),
      .doLog_o       (doLog_o),
      .unit_op_o     (unit_op_o),
      .unit_valid_i  (unit_valid_i),
      .unit_res_i    (unit_res_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_data_o    (rsp_data_o),
      .rsp_timeout_o (rsp_timeout_o),
      .busy_o        (busy_o),
      .done_cnt_o    (done_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [23:0] data;
      logic        tmo;
      int          rise;
   } exp_t;

   typedef struct {
      int          lat;   // cycles from doLog to unit valid; 0 = never answers
      logic [23:0] data;
   } plan_t;

   exp_t        sbq[$];
   plan_t       planq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          ptr = 0;
   int          mcnt = 0;
   bit          outstanding = 0;
   bit          dolog_due = 0;
   bit          front_seen = 0;
   logic [21:0] last_op = '0;
   logic [21:0] opv[NREQ];
   bit          pend[NREQ];
   bit          rnd_en = 0;
   int          req_pct = 30;
   int          force_lat = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input int p);
      for (int i = 0; i < NREQ; i++)
         if (pend[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   // One bench cycle: drive requesters, check control outputs, record accepts.
   task automatic step();
      int          win;
      int          lat;
      int          r;
      logic [23:0] d;
      exp_t        e;
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
         if (rnd_en && !pend[k] && ($urandom_range(99) < req_pct)) begin
            pend[k] = 1;
            opv[k]  = 22'($urandom);
         end
         req_valid_i[k]          = pend[k];
         req_op_i[22*k +: 22]    = opv[k];
      end
      #1;
      check("busy", busy_o, outstanding);
      check("doLog", doLog_o, dolog_due);
      check("unit_op", unit_op_o, last_op);
      check("done_cnt", done_cnt_o, mcnt % (1 << CNT_DW));
      dolog_due = 0;
      win = outstanding ? -1 : rr_pick(ptr);
      check("req_ready", req_ready_o, (win < 0) ? 0 : (1 << win));
      if (win >= 0) begin
         if (force_lat >= 0) lat = force_lat;
         else begin
            r = $urandom_range(9);
            lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT + 1 : (r == 2) ? TIMEOUT + 2 : $urandom_range(5, 1);
         end
         d = 24'($urandom);
         planq.push_back('{lat, d});
         e.idx = win;
         if (lat >= 1 && lat <= TIMEOUT + 1) begin
            e.data = d;    e.tmo = 1'b0; e.rise = cyc + 2 + lat;
         end else begin
            e.data = QNAN; e.tmo = 1'b1; e.rise = cyc + TIMEOUT + 3;
         end
         sbq.push_back(e);
         outstanding = 1;
         dolog_due   = 1;
         last_op     = opv[win];
         pend[win]   = 0;
      end
   endtask

   task automatic drain(input int bound);
      int  n = 0;
      bit  busy_any;
      busy_any = 1;
      while (busy_any && n < bound) begin
         step();
         n++;
         busy_any = outstanding;
         for (int k = 0; k < NREQ; k++) if (pend[k]) busy_any = 1;
      end
      if (busy_any) check("drain_timeout", 1, 0);
   endtask

   // Response monitor: pops the scoreboard on every response handshake.
   initial begin
      exp_t e;
      int   hold = 0;
      bit   rdy;
      rsp_ready_i = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rsp_valid_o == '0) begin
            check("idle_rsp", {rsp_timeout_o, rsp_data_o}, 0);
            rsp_ready_i = NREQ'($urandom);
         end else if (sbq.size() == 0) begin
            check("unexpected_rsp", rsp_valid_o, 0);
            rsp_ready_i = '0;
         end else begin
            e = sbq[0];
            if (!front_seen) begin
               check("rsp_latency", cyc, e.rise);
               front_seen = 1;
               hold = ($urandom_range(3) == 0) ? 10 : 0;
            end
            check("rsp_valid", rsp_valid_o, 1 << e.idx);
            check("rsp_data", rsp_data_o, e.data);
            check("rsp_tmo", rsp_timeout_o, e.tmo);
            if (hold > 0) begin
               rdy = 0;
               hold--;
            end else rdy = ($urandom_range(2) == 0);
            rsp_ready_i        = NREQ'($urandom);
            rsp_ready_i[e.idx] = rdy;
            if (rdy) begin
               void'(sbq.pop_front());
               front_seen  = 0;
               outstanding = 0;
               ptr         = (e.idx + 1) % NREQ;
               mcnt++;
            end
         end
      end
   end

   // Behavioural log unit: answers each doLog after its planned latency, plus stray pulses.
   initial begin
      int          cd = 0;
      logic [23:0] pd = '0;
      bit          was_rsp = 0;
      plan_t       p;
      unit_valid_i = 1'b0;
      unit_res_i   = '0;
      forever begin
         @(negedge clk);
         unit_valid_i = 1'b0;
         unit_res_i   = 24'($urandom);
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               unit_valid_i = 1'b1;
               unit_res_i   = pd;
            end
         end else if (was_rsp && $urandom_range(2) == 0) begin
            unit_valid_i = 1'b1;
         end
         #3;
         was_rsp = (rsp_valid_o != '0);
         if (!rst_n) cd = 0;
         if (doLog_o) begin
            if (planq.size() == 0) check("plan_underflow", 1, 0);
            else begin
               p  = planq.pop_front();
               cd = p.lat;
               pd = p.data;
            end
         end
      end
   end

   initial begin
      req_valid_i = '0;
      req_op_i    = '0;
      for (int k = 0; k < NREQ; k++) begin
         pend[k] = 0;
         opv[k]  = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      check("rst_req_ready", req_ready_o, 0);
      check("rst_doLog", doLog_o, 0);
      check("rst_unit_op", unit_op_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_data", {rsp_timeout_o, rsp_data_o}, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done_cnt", done_cnt_o, 0);
      rst_n = 1'b1;

      // requester 2, bundle 22'h0FF80, unit answers 3 cycles after doLog
      pend[2] = 1; opv[2] = 22'h0FF80; force_lat = 3;
      step();
      drain(100);

      // watchdog abort
      pend[0] = 1; opv[0] = 22'h2A5A5; force_lat = 0;
      step();
      drain(100);

      force_lat = -1;
      rnd_en = 1; req_pct = 30;
      repeat (600) step();
      req_pct = 100;
      repeat (400) step();
      rnd_en = 0;
      drain(400);

      // move the pointer off zero, then hang an operation and reset during WAIT
      pend[1] = 1; opv[1] = 22'h11111; force_lat = 2;
      step();
      drain(100);
      pend[3] = 1; opv[3] = 22'h33333; force_lat = 0;
      step();
      repeat (4) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req_ready", req_ready_o, 0);
      check("arst_doLog", doLog_o, 0);
      check("arst_unit_op", unit_op_o, 0);
      check("arst_rsp_valid", rsp_valid_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_done_cnt", done_cnt_o, 0);
      sbq.delete();
      planq.delete();
      outstanding = 0; dolog_due = 0; front_seen = 0;
      ptr = 0; mcnt = 0; last_op = '0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (20) step();

      pend[1] = 1; opv[1] = 22'h0ABCD;
      pend[3] = 1; opv[3] = 22'h3DCBA;
      force_lat = 1;
      step();
      drain(200);
      check("sb_empty", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
